// File: rtl/piso_sched_pkg.sv
// rtl/piso_sched_pkg.sv - shared state codes and width helpers for the PISO tx scheduler
package piso_sched_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam int GAP_CW = 4;

  function automatic int chan_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_shifter.sv
// rtl/piso_shifter.sv - parallel-load, MSB-first shift register; load wins over shift
module piso_shifter #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_p_in,
  output logic             o_s_out
);

  logic [WIDTH-1:0] r_q;

  // Zeros shift in behind the word, so the MSB reads 0 once a word is fully emitted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_p_in;
    end else if (i_shift) begin
      r_q <= {r_q[WIDTH-2:0], 1'b0};
    end
  end

  assign o_s_out = r_q[WIDTH-1];

endmodule

// File: rtl/piso_tx_scheduler.sv
// rtl/piso_tx_scheduler.sv - round-robin arbiter sequencing one shared PISO shifter onto a serial link
module piso_tx_scheduler
  import piso_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [N_REQ-1:0]             i_req_valid,
  input  logic [N_REQ*WIDTH-1:0]       i_req_data,
  output logic [N_REQ-1:0]             o_req_ready,
  output logic                         o_s_out,
  output logic                         o_s_valid,
  output logic                         o_s_first,
  output logic [chan_w(N_REQ)-1:0]     o_s_chan,
  output logic                         o_busy
);

  localparam int CHW = chan_w(N_REQ);
  localparam int CW  = cnt_w(WIDTH);

  logic [1:0]        r_state;
  logic [CHW-1:0]    r_rr_ptr;
  logic [CW-1:0]     r_bit_cnt;
  logic [GAP_CW-1:0] r_gap_cnt;
  logic              r_s_valid;
  logic              r_s_first;
  logic [CHW-1:0]    r_s_chan;
  logic              r_busy;

  logic [CHW-1:0]    w_grant;
  logic              w_any;
  logic              w_shift_last;
  logic              w_accept_en;
  logic              w_accept;
  logic              w_shift;
  logic [WIDTH-1:0]  w_word;

  // Search starts at r_rr_ptr and wraps, so the last winner goes to the back of the line.
  always_comb begin : p_grant
    int  idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    w_grant = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(r_rr_ptr) + k) % N_REQ;
      if (!found && i_req_valid[idx]) begin
        found   = 1'b1;
        w_grant = CHW'(idx);
      end
    end
  end

  assign w_any        = |i_req_valid;
  assign w_shift_last = (r_state == ST_SHIFT) && (r_bit_cnt == '0);
  assign w_accept_en  = (r_state == ST_IDLE) || ((GAP == 0) && w_shift_last);
  assign w_accept     = !i_rst && w_accept_en && w_any;
  assign w_shift      = (r_state == ST_SHIFT) && !w_accept;
  assign w_word       = i_req_data[int'(w_grant)*WIDTH +: WIDTH];
  assign o_req_ready  = w_accept ? (N_REQ'(1) << w_grant) : '0;

  piso_shifter #(.WIDTH(WIDTH)) u_shifter (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_p_in  (w_word),
    .o_s_out (o_s_out)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_s_valid <= 1'b0;
      r_s_first <= 1'b0;
      r_s_chan  <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_s_first <= 1'b0;
      if (w_accept) begin
        r_state   <= ST_SHIFT;
        r_bit_cnt <= CW'(WIDTH-1);
        r_s_chan  <= w_grant;
        r_rr_ptr  <= (int'(w_grant) == N_REQ-1) ? '0 : w_grant + CHW'(1);
        r_s_valid <= 1'b1;
        r_s_first <= 1'b1;
        r_busy    <= 1'b1;
      end else begin
        case (r_state)
          ST_SHIFT: begin
            if (r_bit_cnt != '0) begin
              r_bit_cnt <= r_bit_cnt - CW'(1);
            end else begin
              r_s_valid <= 1'b0;
              if (GAP > 0) begin
                r_state   <= ST_GAP;
                r_gap_cnt <= GAP_CW'(GAP-1);
              end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end
          end
          ST_GAP: begin
            if (r_gap_cnt == '0) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_gap_cnt <= r_gap_cnt - GAP_CW'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_s_valid = r_s_valid;
  assign o_s_first = r_s_first;
  assign o_s_chan  = r_s_chan;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// tb/tb_piso_tx_scheduler.sv - directed self-checking bench for piso_tx_scheduler
module tb_piso_tx_scheduler;

  logic        clk;
  logic        rst, rst0;
  logic [3:0]  valid, valid0;
  logic [15:0] data, data0;
  logic [3:0]  ready, ready0;
  logic        s_out, s_valid, s_first, busy;
  logic        s_out0, s_valid0, s_first0, busy0;
  logic [1:0]  s_chan, s_chan0;
  logic [5:0]  obs, obs0;

  int n_checks = 0;
  int n_fail   = 0;

  assign obs  = {busy, s_valid, s_first, s_out, s_chan};
  assign obs0 = {busy0, s_valid0, s_first0, s_out0, s_chan0};

  piso_tx_scheduler #(.N_REQ(4), .WIDTH(4), .GAP(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .i_req_data(data),
    .o_req_ready(ready), .o_s_out(s_out), .o_s_valid(s_valid),
    .o_s_first(s_first), .o_s_chan(s_chan), .o_busy(busy)
  );

  piso_tx_scheduler #(.N_REQ(4), .WIDTH(4), .GAP(0)) dut0 (
    .i_clk(clk), .i_rst(rst0), .i_req_valid(valid0), .i_req_data(data0),
    .o_req_ready(ready0), .o_s_out(s_out0), .o_s_valid(s_valid0),
    .o_s_first(s_first0), .o_s_chan(s_chan0), .o_busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst = 1'b1; rst0 = 1'b1;
    valid = 4'hF; valid0 = 4'hF;
    data = 16'h4321; data0 = 16'h4321;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (obs !== 6'b0) $display("FAIL reset_outputs obs=%b exp=%b", obs, 6'b0);
    n_checks++;
    if (ready !== 4'b0) $display("FAIL reset_ready ready=%b exp=%b", ready, 4'b0);
    n_checks++;
    if (obs0 !== 6'b0) $display("FAIL reset_outputs_gap0 obs=%b exp=%b", obs0, 6'b0);
    if (obs !== 6'b0) n_fail++;
    if (ready !== 4'b0) n_fail++;
    if (obs0 !== 6'b0) n_fail++;
    rst = 1'b0; rst0 = 1'b0;
    valid = 4'h0; valid0 = 4'h0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || ready !== 4'b0) begin
        n_fail++;
        $display("FAIL idle_no_req_c%0d busy=%b ready=%b exp busy=0 ready=0000", c, busy, ready);
      end
    end
  endtask

  task automatic test_single;
    logic [5:0] exp [6];
    exp = '{6'b111100, 6'b110000, 6'b110100, 6'b110000, 6'b100000, 6'b000000};
    valid = 4'b0001; data = 16'h000A;
    #1;
    n_checks++;
    if (ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_ready ready=%b exp=%b", ready, 4'b0001);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin
        valid = 4'b0; data = 16'h0005;
      end
      n_checks++;
      if (obs !== exp[c]) begin
        n_fail++;
        $display("FAIL single_c%0d obs=%b exp=%b", c, obs, exp[c]);
      end
    end
  endtask

  task automatic test_round_robin;
    logic [15:0] ser;
    logic [5:0]  e;
    ser = 16'b0001_0010_0011_0100;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    valid = 4'hF; data = 16'h4321;
    #1;
    for (int w = 0; w < 4; w++) begin
      n_checks++;
      if (ready !== (4'b0001 << w) || obs[5:2] !== 4'b0) begin
        n_fail++;
        $display("FAIL rr_grant%0d ready=%b obs=%b exp ready=%b idle", w, ready, obs, 4'b0001 << w);
      end
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        e = {2'b11, (b == 0), ser[15-(w*4+b)], w[1:0]};
        n_checks++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL rr_w%0d_b%0d obs=%b exp=%b", w, b, obs, e);
        end
      end
      @(negedge clk);
      e = {4'b1000, w[1:0]};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL rr_gap%0d obs=%b exp=%b", w, obs, e);
      end
      if (w == 3) valid = 4'b0;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_fairness;
    logic [3:0] gexp [4];
    logic [1:0] cexp [4];
    gexp = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    cexp = '{2'd1, 2'd3, 2'd1, 2'd3};
    valid = 4'b1010; data = 16'h5090;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (ready !== gexp[i]) begin
        n_fail++;
        $display("FAIL fair_grant%0d ready=%b exp=%b", i, ready, gexp[i]);
      end
      @(negedge clk);
      n_checks++;
      if (s_chan !== cexp[i] || s_first !== 1'b1) begin
        n_fail++;
        $display("FAIL fair_chan%0d chan=%0d first=%b exp chan=%0d first=1", i, s_chan, s_first, cexp[i]);
      end
      repeat (4) @(negedge clk);
      if (i == 3) valid = 4'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    valid = 4'b0100; data = 16'h0C80;
    #1;
    n_checks++;
    if (ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL mid_ready ready=%b exp=%b", ready, 4'b0100);
    end
    @(negedge clk);
    n_checks++;
    if (obs !== 6'b111110) begin
      n_fail++;
      $display("FAIL mid_bit0 obs=%b exp=%b", obs, 6'b111110);
    end
    @(negedge clk);
    n_checks++;
    if (obs !== 6'b110110) begin
      n_fail++;
      $display("FAIL mid_bit1 obs=%b exp=%b", obs, 6'b110110);
    end
    rst = 1'b1; valid = 4'b1010;
    @(negedge clk);
    n_checks++;
    if (obs !== 6'b0 || ready !== 4'b0) begin
      n_fail++;
      $display("FAIL mid_abort obs=%b ready=%b exp obs=000000 ready=0000", obs, ready);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL mid_rr_from0 ready=%b exp=%b", ready, 4'b0010);
    end
    @(negedge clk);
    n_checks++;
    if (obs !== 6'b111101) begin
      n_fail++;
      $display("FAIL mid_restart obs=%b exp=%b", obs, 6'b111101);
    end
    valid = 4'b0;
    for (int k = 0; k < 20 && busy !== 1'b0; k++) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_drain busy=%b exp=0", busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ser;
    logic [5:0] e;
    ser = 8'b1001_0110;
    valid0 = 4'b0100; data0 = 16'h0900;
    #1;
    n_checks++;
    if (ready0 !== 4'b0100) begin
      n_fail++;
      $display("FAIL b2b_ready0 ready=%b exp=%b", ready0, 4'b0100);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      e = {2'b11, (c == 0 || c == 4), ser[7-c], 2'd2};
      n_checks++;
      if (obs0 !== e) begin
        n_fail++;
        $display("FAIL b2b_c%0d obs=%b exp=%b", c, obs0, e);
      end
      if (c == 1) begin
        data0 = 16'h0600;
        n_checks++;
        if (ready0 !== 4'b0) begin
          n_fail++;
          $display("FAIL b2b_no_early_ready ready=%b exp=%b", ready0, 4'b0);
        end
      end
      if (c == 3) begin
        n_checks++;
        if (ready0 !== 4'b0100) begin
          n_fail++;
          $display("FAIL b2b_ready1 ready=%b exp=%b", ready0, 4'b0100);
        end
      end
      if (c == 4) valid0 = 4'b0;
    end
    @(negedge clk);
    n_checks++;
    if ({busy0, s_valid0} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_end busy=%b valid=%b exp 0 0", busy0, s_valid0);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_fairness;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
